flash_loader: RTL and testbench

- Writer-side counterpart of the program flash memory: a byte-stream programmer.
- Receives a framed byte stream from a host link: count, data, checksum.
- Assembles little-endian 16-bit instruction words and drives the flash write port at sequential addresses from 0.
- Holds the CPU core (cpu_hold) while loading; reports done/error to the host.

---
 rtl/fm_pkg.sv | 31 +++
 rtl/flash_loader.sv | 138 +++++++++++++
 tb/tb_flash_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_pkg.sv
// fm_pkg: constants and helpers shared between the program flash memory and
// its byte-stream loader.
//   SIZE_INST  - instruction word width in bits
//   SIZE_FM    - flash word address width in bits
//   fm_state_t - loader FSM state encoding (3 bits)
//   chk_seed / chk_next - running XOR checksum over the framed byte stream
package fm_pkg;

    localparam int SIZE_INST = 16;
    localparam int SIZE_FM   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } fm_state_t;

    // The checksum covers the count byte and every data byte.
    function automatic logic [7:0] chk_seed(input logic [7:0] b);
        return b;
    endfunction

    function automatic logic [7:0] chk_next(input logic [7:0] c, input logic [7:0] b);
        return c ^ b;
    endfunction

endpackage

// File: rtl/flash_loader.sv
// flash_loader: byte-stream programmer for the program flash.
// Frame from the host: N (0 means 256 words), then N little-endian 16-bit
// words (low byte first), then an XOR checksum over all preceding bytes.
// Ports:
//   clk_fm, rst_fm         - clock (rising edge), asynchronous active-high reset
//   start, abort           - session control from the host
//   byte_in, byte_valid    - stream byte and its valid
//   byte_ready             - loader accepts a byte this cycle
//   wr_en, wr_addr, wr_data- flash write port, one strobe per word
//   cpu_hold, busy         - core stall / session in progress
//   done, error            - sticky session result, cleared by start
//   words_written          - words written in this session
module flash_loader #(
    parameter int SIZE_INST = fm_pkg::SIZE_INST,
    parameter int SIZE_FM   = fm_pkg::SIZE_FM
) (
    input  logic                 clk_fm,
    input  logic                 rst_fm,
    input  logic                 start,
    input  logic                 abort,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 wr_en,
    output logic [SIZE_FM-1:0]   wr_addr,
    output logic [SIZE_INST-1:0] wr_data,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [SIZE_FM:0]     words_written
);

    import fm_pkg::*;

    fm_state_t          state, state_nxt;
    logic [7:0]         low_byte;
    logic [7:0]         chk;
    logic [SIZE_FM:0]   words_left;
    logic               active;
    logic               take_p0;
    logic               hi_vld_p0;

    // byte_ready decodes the state register only, so it never depends on
    // byte_valid in the same cycle.
    assign active     = (state == ST_COUNT) || (state == ST_LOW) ||
                        (state == ST_HIGH)  || (state == ST_CHECK);
    assign byte_ready = active;

    // abort beats a simultaneous transfer: the byte stays with the source.
    assign take_p0   = byte_valid && byte_ready && !abort;
    assign hi_vld_p0 = take_p0 && (state == ST_HIGH);

    // The final write strobe can overlap leaving the active states (abort
    // right after the last high byte), so the core is held through it.
    assign busy     = active || wr_en;
    assign cpu_hold = busy;
    assign done     = (state == ST_DONE);
    assign error    = (state == ST_ERROR);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                if (abort)        state_nxt = ST_ERROR;
                else if (take_p0) state_nxt = ST_LOW;
            end
            ST_LOW: begin
                if (abort)        state_nxt = ST_ERROR;
                else if (take_p0) state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                if (abort)        state_nxt = ST_ERROR;
                else if (take_p0) state_nxt = (words_left == (SIZE_FM+1)'(1)) ? ST_CHECK : ST_LOW;
            end
            ST_CHECK: begin
                if (abort)        state_nxt = ST_ERROR;
                else if (take_p0) state_nxt = (byte_in == chk) ? ST_DONE : ST_ERROR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- stage p0 -> p1: byte capture, checksum, word assembly ----
    always_ff @(posedge clk_fm or posedge rst_fm) begin
        if (rst_fm) begin
            state         <= ST_IDLE;
            low_byte      <= '0;
            chk           <= '0;
            words_left    <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            words_written <= '0;
        end else begin
            state <= state_nxt;
            wr_en <= hi_vld_p0;

            if (take_p0) begin
                case (state)
                    ST_COUNT: begin
                        words_left <= (byte_in == 8'd0) ? (SIZE_FM+1)'(256)
                                                        : (SIZE_FM+1)'(byte_in);
                        chk        <= chk_seed(byte_in);
                    end
                    ST_LOW: begin
                        low_byte <= byte_in;
                        chk      <= chk_next(chk, byte_in);
                    end
                    ST_HIGH: begin
                        wr_data    <= SIZE_INST'({byte_in, low_byte});
                        words_left <= words_left - (SIZE_FM+1)'(1);
                        chk        <= chk_next(chk, byte_in);
                    end
                    default: ;
                endcase
            end

            // ---- stage p1 -> p2: advance address after the strobe cycle ----
            if (wr_en) begin
                wr_addr       <= wr_addr + SIZE_FM'(1);
                words_written <= words_written + (SIZE_FM+1)'(1);
            end

            // A new session restarts addressing; wr_en is never high in the
            // idle states, so this cannot collide with the increment above.
            if (start && !active) begin
                chk           <= '0;
                wr_addr       <= '0;
                words_written <= '0;
            end
        end
    end

endmodule

// File: tb/tb_flash_loader.sv
module tb_flash_loader;

    logic        clk_fm = 1'b0;
    logic        rst_fm;
    logic        start;
    logic        abort;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_written;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t sb_q[$];

    flash_loader dut (
        .clk_fm       (clk_fm),
        .rst_fm       (rst_fm),
        .start        (start),
        .abort        (abort),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_written(words_written)
    );

    always #5 clk_fm = ~clk_fm;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk_fm) begin
        if (wr_en) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h required no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d) begin
                    bad++;
                    $display("FAIL write: got addr=%0d data=%h required addr=%0d data=%h",
                             wr_addr, wr_data, e.a, e.d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name, input logic d, input logic e,
                                input int ww, input logic bsy);
        check({name, ".done"},  {31'd0, done},  {31'd0, d});
        check({name, ".error"}, {31'd0, error}, {31'd0, e});
        check({name, ".words"}, {23'd0, words_written}, ww);
        check({name, ".busy"},  {31'd0, busy},  {31'd0, bsy});
        check({name, ".hold"},  {31'd0, cpu_hold}, {31'd0, bsy});
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk_fm); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic with_start);
        int guard;
        repeat (gap) begin @(posedge clk_fm); #1; end
        byte_in    = b;
        byte_valid = 1'b1;
        start      = with_start;
        guard      = 0;
        while (!byte_ready && guard < 50) begin
            @(posedge clk_fm); #1;
            guard++;
        end
        if (!byte_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got byte_ready=0 required 1");
        end
        @(posedge clk_fm); #1;
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_fm); #1; end
    endtask

    initial begin
        rst_fm     = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        idle(2);
        check("rst.wr_en",      {31'd0, wr_en}, 0);
        check("rst.wr_addr",    {24'd0, wr_addr}, 0);
        check("rst.byte_ready", {31'd0, byte_ready}, 0);
        check_status("rst", 1'b0, 1'b0, 0, 1'b0);
        rst_fm = 1'b0;
        idle(2);

        // 1: two-word frame, good checksum 0x31
        expect_wr(8'd0, 16'h210E);
        expect_wr(8'd1, 16'h0D11);
        pulse_start();
        check("t1.ready", {31'd0, byte_ready}, 1);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h0E, 0, 1'b0);
        send_byte(8'h21, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h0D, 0, 1'b0);
        send_byte(8'h31, 0, 1'b0);
        idle(2);
        check_status("t1", 1'b1, 1'b0, 2, 1'b0);
        check("t1.sb_empty", sb_q.size(), 0);

        // 2: same frame, bad checksum
        expect_wr(8'd0, 16'h210E);
        expect_wr(8'd1, 16'h0D11);
        pulse_start();
        check_status("t2.cleared", 1'b0, 1'b0, 0, 1'b1);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h0E, 0, 1'b0);
        send_byte(8'h21, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h0D, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        idle(2);
        check_status("t2", 1'b0, 1'b1, 2, 1'b0);
        pulse_start();
        check_status("t2.restart", 1'b0, 1'b0, 0, 1'b1);

        // 3: N=0 -> 256 words {~w, w}; XOR over all bytes is 0x00
        for (int w = 0; w < 256; w++) expect_wr(8'(w), {~8'(w), 8'(w)});
        send_byte(8'h00, 0, 1'b0);
        for (int w = 0; w < 256; w++) begin
            send_byte(8'(w), 0, 1'b0);
            send_byte(~8'(w), 0, 1'b0);
        end
        send_byte(8'h00, 0, 1'b0);
        idle(3);
        check_status("t3", 1'b1, 1'b0, 256, 1'b0);
        check("t3.addr_wrap", {24'd0, wr_addr}, 0);
        check("t3.sb_empty", sb_q.size(), 0);

        // 4: abort while in HIGH with a byte offered
        pulse_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        abort      = 1'b1;
        @(posedge clk_fm); #1;
        abort      = 1'b0;
        check("t4.ready", {31'd0, byte_ready}, 0);
        byte_valid = 1'b0;
        idle(3);
        check_status("t4", 1'b0, 1'b1, 0, 1'b0);
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        check("t4.abort_idle", {31'd0, error}, 1);

        // 5: reset in the middle of a three-word frame
        expect_wr(8'd0, 16'h1234);
        pulse_start();
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        rst_fm = 1'b1;
        #1;
        check("t5.wr_en",   {31'd0, wr_en}, 0);
        check("t5.wr_addr", {24'd0, wr_addr}, 0);
        check("t5.wr_data", {16'd0, wr_data}, 0);
        check("t5.ready",   {31'd0, byte_ready}, 0);
        check_status("t5.rst", 1'b0, 1'b0, 0, 1'b0);
        idle(2);
        rst_fm = 1'b0;
        idle(1);
        expect_wr(8'd0, 16'h5678);
        pulse_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h78, 0, 1'b0);
        send_byte(8'h56, 0, 1'b0);
        send_byte(8'h2F, 0, 1'b0);
        idle(2);
        check_status("t5.after", 1'b1, 1'b0, 1, 1'b0);
        check("t5.sb_empty", sb_q.size(), 0);

        // 6: frame of test 1 with gaps and start pulses while busy
        expect_wr(8'd0, 16'h210E);
        expect_wr(8'd1, 16'h0D11);
        pulse_start();
        send_byte(8'h02, $urandom_range(0, 3), 1'b1);
        send_byte(8'h0E, $urandom_range(0, 3), 1'b0);
        send_byte(8'h21, $urandom_range(0, 3), 1'b1);
        send_byte(8'h11, $urandom_range(0, 3), 1'b0);
        send_byte(8'h0D, $urandom_range(0, 3), 1'b1);
        send_byte(8'h31, $urandom_range(0, 3), 1'b0);
        idle(2);
        check_status("t6", 1'b1, 1'b0, 2, 1'b0);
        check("t6.sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
